multdiv_issue: RTL and testbench
================================

Name: multdiv_issue

Overview:
- Execute-stage sequencer sitting directly upstream and downstream of the iterative multiplier/divider unit.
- Accepts a mult/div instruction from execute and latches its operands and destination register.
- Issues a one-cycle start pulse to the unit, stalls the pipeline until the unit reports ready, then presents a single-cycle writeback, redirecting exceptions to the status register.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles in BUSY before the operation is forced to an exception.
- STATUS_REG, 30: writeback register index used on exception.
- MULT_EXC_CODE, 4: status value written on multiply exception or timeout.
- DIV_EXC_CODE, 5: status value written on divide exception or timeout.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (reset==0 at a rising edge resets the block).
- issue_valid  in  1  execute holds a mult/div instruction this cycle.
- issue_is_mult  in  1  instruction is a multiply.
- issue_is_div  in  1  instruction is a divide.
- issue_opA  in  32  operand A.
- issue_opB  in  32  operand B.
- issue_rd  in  5  destination register.
- flush  in  1  abandon any in-flight operation (branch/jump squash).
- data_operandA  out  32  latched operand A to the unit.
- data_operandB  out  32  latched operand B to the unit.
- ctrl_MULT  out  1  one-cycle multiply start pulse.
- ctrl_DIV  out  1  one-cycle divide start pulse.
- data_result  in  32  unit result.
- data_exception  in  1  unit exception flag.
- data_resultRDY  in  1  unit result valid.
- stall  out  1  freeze fetch/decode/execute.
- wb_valid  out  1  writeback strobe, one cycle.
- wb_rd  out  5  writeback register.
- wb_data  out  32  writeback value.
- illegal  out  1  registered pulse: both is_mult and is_div were asserted with issue_valid.

Behaviour:
- States: IDLE, START, BUSY, DONE, encoded 2 bits. Reset → IDLE.
- Reset values: all outputs 0, operand/rd/op latches 0, timeout counter 0.
- IDLE:
  - If issue_valid and exactly one of is_mult/is_div is high and flush is low: latch opA, opB, rd and op type; go to START.
  - stall is combinationally high in this accept cycle.
- START:
  - ctrl_MULT or ctrl_DIV is high for exactly this one cycle, per the latched op.
  - data_operandA/B are stable from START until return to IDLE.
  - Always go to BUSY; data_resultRDY is ignored in START, since the unit may still hold a stale ready flag.
- BUSY:
  - Counter increments each cycle.
  - If data_resultRDY=1: capture result and exception, go to DONE.
  - Else if counter == TIMEOUT_CYCLES-1: capture a forced exception, go to DONE.
- DONE:
  - wb_valid=1 for this cycle only; stall=0; return to IDLE.
  - Normal result: wb_rd=latched rd, wb_data=captured result.
  - Exception or timeout: wb_rd=STATUS_REG, wb_data=MULT_EXC_CODE or DIV_EXC_CODE by op type.
- wb_rd and wb_data are 0 whenever wb_valid=0.
- stall = (IDLE and accepting) or START or BUSY.
- Latency: accept at cycle 0, pulse at cycle 1. First RDY sampled in BUSY at cycle k ≥ 2 gives wb_valid at k+1. stall is high for cycles 0..k.
- Illegal issue (both op flags high): no accept, no stall, illegal=1 in the next cycle; remain in IDLE.
- issue_valid with neither flag high: ignored.
- flush:
  - In IDLE, it blocks acceptance.
  - In START or BUSY, go to IDLE next cycle with no writeback and no pulse; the counter is cleared. The unit's stray result is discarded because RDY is only sampled in BUSY, and the next op's pulse restarts the unit.
  - In DONE, writeback still occurs.
- A new issue cannot be accepted in DONE. An instruction presented in the DONE cycle is accepted the following cycle in IDLE.
- Reset mid-operation: immediate return to IDLE at that edge, no pulse, no writeback.
- Operand, rd and op-type latches are written only on accept.

Test Plan:
- Reset low for 2 cycles, then high → all outputs 0, state IDLE, stall=0.
- Issue mult, opA=7, opB=-3, rd=5; RDY at cycle 20 with result=-21 → ctrl_MULT high only at cycle 1; stall high cycles 0–20; cycle 21 wb_valid=1, wb_rd=5, wb_data=0xFFFFFFEB.
- Issue div, opA=100, opB=0; unit returns exception=1 → ctrl_DIV pulse at cycle 1; writeback has wb_rd=30, wb_data=5.
- Issue mult with data_resultRDY held 1 from the previous op through START → RDY is ignored in START; completion occurs at the first BUSY cycle with RDY=1. With RDY never asserted: wb_rd=30, wb_data=4 at BUSY entry + 64.
- Issue div, assert flush at cycle 5 → cycle 6 IDLE, stall=0, no wb_valid. A later issue of mult 3×4, rd=2, is accepted normally and writes back 12.
- issue_valid with both is_mult and is_div → no stall, no ctrl pulse, illegal=1 next cycle. Reset asserted during BUSY → IDLE next edge, no wb_valid.

Source files
------------

// File: rtl/multdiv_issue.sv
// Issue/writeback sequencer wrapped around the iterative multiplier/divider.
// It accepts one mult/div instruction, sends a single start pulse, and stalls
// the pipeline until the unit is ready or the timeout expires. It then
// presents one writeback cycle, which goes to the status register on exception.
module multdiv_issue #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [4:0]  STATUS_REG     = 5'd30,
    parameter logic [31:0] MULT_EXC_CODE  = 32'd4,
    parameter logic [31:0] DIV_EXC_CODE   = 32'd5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        issue_is_mult,
    input  logic        issue_is_div,
    input  logic [31:0] issue_opA,
    input  logic [31:0] issue_opB,
    input  logic [4:0]  issue_rd,
    input  logic        flush,
    output logic [31:0] data_operandA,
    output logic [31:0] data_operandB,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    input  logic [31:0] data_result,
    input  logic        data_exception,
    input  logic        data_resultRDY,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        illegal
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

    state_t        state;
    state_t        state_next;
    logic          accept;
    logic          timed_out;
    logic [CW-1:0] count;
    logic          op_mult;
    logic [4:0]    rd_q;
    logic [31:0]   result_q;
    logic          exc_q;

    assign timed_out = (count == CW'(TIMEOUT_CYCLES - 1));

    // State register; reset and flush both return to IDLE.
    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state selection and the outputs derived from the current state.
    // The ready flag is ignored in START because the unit may still be holding
    // a stale ready from the previous operation.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        ctrl_MULT  = 1'b0;
        ctrl_DIV   = 1'b0;
        stall      = 1'b0;
        wb_valid   = 1'b0;
        wb_rd      = '0;
        wb_data    = '0;
        case (state)
            IDLE: begin
                if (issue_valid && (issue_is_mult ^ issue_is_div) && !flush) begin
                    accept     = 1'b1;
                    stall      = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                ctrl_MULT  = op_mult;
                ctrl_DIV   = !op_mult;
                stall      = 1'b1;
                state_next = flush ? IDLE : BUSY;
            end
            BUSY: begin
                stall = 1'b1;
                if (flush)                            state_next = IDLE;
                else if (data_resultRDY || timed_out) state_next = DONE;
            end
            DONE: begin
                wb_valid   = 1'b1;
                wb_rd      = exc_q ? STATUS_REG : rd_q;
                wb_data    = exc_q ? (op_mult ? MULT_EXC_CODE : DIV_EXC_CODE) : result_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand/rd latches, timeout counter, result capture and illegal-issue flag.
    always_ff @(posedge clock) begin
        if (!reset) begin
            data_operandA <= '0;
            data_operandB <= '0;
            rd_q          <= '0;
            op_mult       <= 1'b0;
            count         <= '0;
            result_q      <= '0;
            exc_q         <= 1'b0;
            illegal       <= 1'b0;
        end else begin
            illegal <= issue_valid && issue_is_mult && issue_is_div;
            if (accept) begin
                data_operandA <= issue_opA;
                data_operandB <= issue_opB;
                rd_q          <= issue_rd;
                op_mult       <= issue_is_mult;
            end
            if (state == BUSY && state_next == BUSY) count <= count + 1'b1;
            else                                     count <= '0;
            // A timeout completion is recorded as an exception. RDY takes
            // precedence when it arrives in the final allowed cycle.
            if (state == BUSY && state_next == DONE) begin
                result_q <= data_result;
                exc_q    <= !data_resultRDY || data_exception;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_issue.sv
// Bench for multdiv_issue. An abstract model tracks each instruction by its age
// in cycles since it was accepted. A per-cycle compare checks every output
// against that model. Directed scenarios pin the model with literal values,
// and a randomized phase follows.
module tb_multdiv_issue;

    localparam int TMO = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        issue_valid = 1'b0, issue_is_mult = 1'b0, issue_is_div = 1'b0;
    logic [31:0] issue_opA = '0, issue_opB = '0;
    logic [4:0]  issue_rd = '0;
    logic        flush = 1'b0;
    logic [31:0] data_operandA, data_operandB;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] data_result = '0;
    logic        data_exception = 1'b0, data_resultRDY = 1'b0;
    logic        stall, wb_valid, illegal;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    always #5 clock = ~clock;

    multdiv_issue #(
        .TIMEOUT_CYCLES(TMO),
        .STATUS_REG(5'd30),
        .MULT_EXC_CODE(32'd4),
        .DIV_EXC_CODE(32'd5)
    ) dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_is_mult(issue_is_mult), .issue_is_div(issue_is_div),
        .issue_opA(issue_opA), .issue_opB(issue_opB), .issue_rd(issue_rd), .flush(flush),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .data_result(data_result), .data_exception(data_exception), .data_resultRDY(data_resultRDY),
        .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .illegal(illegal)
    );

    // Reference model state: an in-flight instruction is identified by its age.
    bit          m_known = 0;
    bit          m_busy = 0;
    int          m_age = 0;
    bit          m_wb = 0;
    logic [4:0]  m_wb_rd = '0;
    logic [31:0] m_wb_data = '0;
    bit          m_ill = 0;
    logic [31:0] m_opA = '0, m_opB = '0;
    bit          m_mult = 0;
    logic [4:0]  m_rd = '0;

    int unsigned n_total = 0, n_pass = 0;

    logic        s_stall, s_wb_valid, s_ctrl_mult, s_ctrl_div, s_illegal;
    logic [4:0]  s_wb_rd;
    logic [31:0] s_wb_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // One clock cycle: compare outputs at the negedge, then advance the model at the posedge.
    task automatic step();
        bit idle, acc;
        @(negedge clock);
        idle = !m_busy && !m_wb;
        acc  = idle && issue_valid && (issue_is_mult != issue_is_div) && !flush;
        if (m_known) begin
            chk("stall",    stall,    acc || m_busy);
            chk("ctrl_MULT", ctrl_MULT, m_busy && m_age == 1 && m_mult);
            chk("ctrl_DIV",  ctrl_DIV,  m_busy && m_age == 1 && !m_mult);
            chk("wb_valid", wb_valid, m_wb);
            chk("wb_rd",    wb_rd,    m_wb ? m_wb_rd : 5'd0);
            chk("wb_data",  wb_data,  m_wb ? m_wb_data : 32'd0);
            chk("illegal",  illegal,  m_ill);
            chk("operandA", data_operandA, m_opA);
            chk("operandB", data_operandB, m_opB);
        end
        s_stall = stall; s_wb_valid = wb_valid; s_wb_rd = wb_rd; s_wb_data = wb_data;
        s_ctrl_mult = ctrl_MULT; s_ctrl_div = ctrl_DIV; s_illegal = illegal;
        @(posedge clock);
        if (!reset) begin
            m_known = 1; m_busy = 0; m_age = 0; m_wb = 0; m_ill = 0;
            m_opA = '0; m_opB = '0; m_mult = 0; m_rd = '0;
        end else begin
            m_ill = issue_valid && issue_is_mult && issue_is_div;
            m_wb  = 0;
            if (m_busy) begin
                if (flush) m_busy = 0;
                else if (m_age >= 2 && (data_resultRDY || m_age - 2 == TMO - 1)) begin
                    m_busy = 0;
                    m_wb   = 1;
                    if (!data_resultRDY || data_exception) begin
                        m_wb_rd   = 5'd30;
                        m_wb_data = m_mult ? 32'd4 : 32'd5;
                    end else begin
                        m_wb_rd   = m_rd;
                        m_wb_data = data_result;
                    end
                end else m_age++;
            end
            if (acc) begin
                m_busy = 1; m_age = 1;
                m_opA = issue_opA; m_opB = issue_opB; m_rd = issue_rd; m_mult = issue_is_mult;
            end
        end
        #1;
    endtask

    task automatic issue(input bit mul, input bit dv, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        issue_valid = 1; issue_is_mult = mul; issue_is_div = dv;
        issue_opA = a; issue_opB = b; issue_rd = rd;
        step();
        issue_valid = 0; issue_is_mult = 0; issue_is_div = 0;
    endtask

    // Drive RDY over cycles [rdy_from, rdy_until] relative to accept; bounded wait for writeback.
    int wb_cyc, pulse_cyc, stall_cnt;
    task automatic run_until_wb(input int rdy_from, input int rdy_until,
                                input logic [31:0] res, input bit exc);
        wb_cyc = -1; pulse_cyc = -1;
        for (int cyc = 1; cyc <= 120; cyc++) begin
            data_resultRDY = (cyc >= rdy_from && cyc <= rdy_until);
            data_result = res; data_exception = exc;
            step();
            if ((s_ctrl_mult || s_ctrl_div) && pulse_cyc < 0) pulse_cyc = cyc;
            if (s_stall) stall_cnt++;
            if (s_wb_valid) begin wb_cyc = cyc; break; end
        end
        data_resultRDY = 0; data_exception = 0; data_result = '0;
        if (wb_cyc < 0) chk("wb_timeout_bound", 32'd0, 32'd1);
    endtask

    initial begin
        // Reset for two cycles.
        reset = 0;
        step(); step();
        reset = 1;
        step();
        chk("reset_stall", s_stall, 0);
        chk("reset_wb_valid", s_wb_valid, 0);

        // Multiply 7 * -3 into r5, with the unit ready at cycle 20.
        issue(1, 0, 32'd7, 32'hFFFF_FFFD, 5'd5);
        stall_cnt = s_stall ? 1 : 0;
        run_until_wb(20, 20, 32'hFFFF_FFEB, 0);
        chk("mult_pulse_cycle", pulse_cyc, 1);
        chk("mult_stall_cycles", stall_cnt, 21);
        chk("mult_wb_cycle", wb_cyc, 21);
        chk("mult_wb_rd", s_wb_rd, 5);
        chk("mult_wb_data", s_wb_data, 32'hFFFF_FFEB);

        // Divide by zero; the unit reports an exception at cycle 2.
        issue(0, 1, 32'd100, 32'd0, 5'd9);
        run_until_wb(2, 2, 32'd0, 1);
        chk("div_exc_wb_cycle", wb_cyc, 3);
        chk("div_exc_wb_rd", s_wb_rd, 30);
        chk("div_exc_wb_data", s_wb_data, 5);

        // Stale RDY through START, then RDY never returns, so the timeout fires.
        data_resultRDY = 1;
        issue(1, 0, 32'd1, 32'd2, 5'd7);
        run_until_wb(1, 1, 32'd0, 0);
        chk("timeout_wb_cycle", wb_cyc, 2 + TMO);
        chk("timeout_wb_rd", s_wb_rd, 30);
        chk("timeout_wb_data", s_wb_data, 4);

        // RDY held through START and BUSY completes at the first BUSY cycle.
        data_resultRDY = 1; data_result = 32'd55;
        issue(1, 0, 32'd5, 32'd11, 5'd3);
        run_until_wb(1, 200, 32'd55, 0);
        chk("held_rdy_wb_cycle", wb_cyc, 3);
        chk("held_rdy_wb_data", s_wb_data, 55);

        // Flush of an in-flight divide at cycle 5.
        issue(0, 1, 32'd9, 32'd3, 5'd4);
        for (int c = 1; c <= 4; c++) step();
        flush = 1; step(); flush = 0;
        step();
        chk("flush_stall", s_stall, 0);
        chk("flush_wb_valid", s_wb_valid, 0);
        issue(1, 0, 32'd3, 32'd4, 5'd2);
        run_until_wb(4, 4, 32'd12, 0);
        chk("post_flush_wb_rd", s_wb_rd, 2);
        chk("post_flush_wb_data", s_wb_data, 12);

        // Illegal issue with both op flags set.
        issue(1, 1, 32'd1, 32'd1, 5'd1);
        chk("illegal_no_stall", s_stall, 0);
        step();
        chk("illegal_flag", s_illegal, 1);
        chk("illegal_no_pulse", s_ctrl_mult | s_ctrl_div, 0);

        // Reset asserted during BUSY.
        issue(1, 0, 32'd8, 32'd8, 5'd6);
        step(); step();
        reset = 0; step(); reset = 1;
        step();
        chk("mid_reset_wb_valid", s_wb_valid, 0);
        chk("mid_reset_stall", s_stall, 0);

        // Randomized traffic; some phases starve RDY so that timeouts occur.
        for (int ph = 0; ph < 6; ph++) begin
            int rdy_div;
            rdy_div = (ph % 3 == 2) ? 0 : (ph % 3 == 0 ? 3 : 12);
            for (int c = 0; c < 500; c++) begin
                issue_valid    = ($urandom % 3) == 0;
                issue_is_mult  = $urandom % 2;
                issue_is_div   = ($urandom % 4 == 0) ? issue_is_mult : !issue_is_mult;
                issue_opA      = $urandom;
                issue_opB      = $urandom;
                issue_rd       = 5'($urandom);
                flush          = ($urandom % 25) == 0;
                data_resultRDY = (rdy_div != 0) && (($urandom % rdy_div) == 0);
                data_result    = $urandom;
                data_exception = ($urandom % 5) == 0;
                reset          = !(($urandom % 400) == 0);
                step();
            end
        end
        issue_valid = 0; flush = 0; data_resultRDY = 0; reset = 1;
        for (int c = 0; c < 4; c++) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
